// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register,
// same-cycle write-to-read forwarding and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic             sb_set_en,
    input  logic [AW-1:0]    sb_set_addr
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_nxt;

    // Completed writes retire their producer; a new issue in the same cycle wins.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NW; k++) begin
            if (wr_en[k]) begin
                busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_en) begin
            busy_nxt[sb_set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int k = 0; k < NW; k++) begin
                if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*AW +: AW] == '0)) begin
                    mem[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
                end
            end
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] d;
        logic          hit;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            d   = mem[ra];
            hit = 1'b0;
            if (BYPASS != 0 && !rst) begin
                for (int k = 0; k < NW; k++) begin
                    if (wr_en[k] && wr_addr[k*AW +: AW] == ra) begin
                        d   = wr_data[k*DW +: DW];
                        hit = 1'b1;
                    end
                end
            end
            if (ZERO_REG != 0 && ra == '0) begin
                d = '0;
            end
        end

        assign rd_data[i*DW +: DW] = d;
        assign rd_busy[i]          = busy[ra] & ~hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream,
// directed vectors first, then random traffic against an array model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int D  = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             sb_set_en;
    logic [AW-1:0]    sb_set_addr;

    logic [NR*DW-1:0] rd_data_a, rd_data_b, rd_data_c;
    logic [NR-1:0]    rd_busy_a, rd_busy_b, rd_busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: zero reg + bypass, b: zero reg without bypass, c: bypass without zero reg
    regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));
    regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));
    regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));

    typedef struct {
        int unsigned rst, we, wa0, wd0, wa1, wd1, sbe, sba, ra0, ra1, chk;
        int unsigned ea0, ea1, eab, eb0, eb1, ebb;
    } vec_t;

    vec_t tbl [26];

    // Reference state per configuration
    bit [DW-1:0] m  [3][D];
    bit          bz [3][D];

    function automatic bit zr(int j);
        return j != 2;
    endfunction

    function automatic bit by(int j);
        return j != 1;
    endfunction

    function automatic bit fwd_hit(int j, int i);
        bit h = 1'b0;
        if (by(j) && !rst)
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[i*AW +: AW]) h = 1'b1;
        return h;
    endfunction

    function automatic logic [DW-1:0] exp_data(int j, int i);
        int unsigned a = int'(rd_addr[i*AW +: AW]);
        logic [DW-1:0] r = m[j][a];
        if (zr(j) && a == 0) return '0;
        if (by(j) && !rst)
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) r = wr_data[k*DW +: DW];
        return r;
    endfunction

    function automatic logic exp_busy(int j, int i);
        if (fwd_hit(j, i)) return 1'b0;
        return bz[j][rd_addr[i*AW +: AW]];
    endfunction

    task automatic model_edge();
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                for (int a = 0; a < D; a++) begin
                    m[j][a]  = '0;
                    bz[j][a] = 1'b0;
                end
            end else begin
                for (int k = 0; k < NW; k++) begin
                    if (wr_en[k]) begin
                        if (!(zr(j) && wr_addr[k*AW +: AW] == 0))
                            m[j][wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
                        bz[j][wr_addr[k*AW +: AW]] = 1'b0;
                    end
                end
                if (sb_set_en) bz[j][sb_set_addr] = 1'b1;
                if (zr(j)) bz[j][0] = 1'b0;
            end
        end
    endtask

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pick_d(int j, int i);
        case (j)
            0:       return rd_data_a[i*DW +: DW];
            1:       return rd_data_b[i*DW +: DW];
            default: return rd_data_c[i*DW +: DW];
        endcase
    endfunction

    function automatic logic pick_b(int j, int i);
        case (j)
            0:       return rd_busy_a[i];
            1:       return rd_busy_b[i];
            default: return rd_busy_c[i];
        endcase
    endfunction

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; rd_addr = '0;

        //         rst we wa0 wd0    wa1 wd1    sbe sba ra0 ra1 chk  ea0    ea1    eab eb0    eb1    ebb
        tbl[0]  = '{1, 1, 3, 'h55,  0, 0,     0, 0, 3, 3, 0,   0,     0,     0,  0,     0,     0};
        tbl[1]  = '{1, 1, 3, 'h55,  0, 0,     0, 0, 3, 3, 1,   0,     0,     0,  0,     0,     0};
        tbl[2]  = '{0, 0, 0, 0,     0, 0,     0, 0, 3, 3, 1,   0,     0,     0,  0,     0,     0};
        tbl[3]  = '{0, 1, 1, 'h2,   0, 0,     0, 0, 1, 2, 1,   'h2,   0,     0,  0,     0,     0};
        tbl[4]  = '{0, 1, 2, 'h3,   0, 0,     0, 0, 1, 2, 1,   'h2,   'h3,   0,  'h2,   0,     0};
        tbl[5]  = '{0, 1, 3, 'h4,   0, 0,     0, 0, 3, 2, 1,   'h4,   'h3,   0,  0,     'h3,   0};
        tbl[6]  = '{0, 0, 0, 0,     0, 0,     0, 0, 1, 2, 1,   'h2,   'h3,   0,  'h2,   'h3,   0};
        tbl[7]  = '{0, 0, 0, 0,     0, 0,     0, 0, 3, 2, 1,   'h4,   'h3,   0,  'h4,   'h3,   0};
        tbl[8]  = '{0, 1, 0, 'hF,   0, 0,     0, 0, 0, 3, 1,   0,     'h4,   0,  0,     'h4,   0};
        tbl[9]  = '{0, 0, 0, 0,     0, 0,     0, 0, 0, 1, 1,   0,     'h2,   0,  0,     'h2,   0};
        tbl[10] = '{0, 1, 5, 'hA,   0, 0,     0, 0, 5, 5, 1,   'hA,   'hA,   0,  0,     0,     0};
        tbl[11] = '{0, 1, 5, 'hB,   0, 0,     0, 0, 5, 0, 1,   'hB,   0,     0,  'hA,   0,     0};
        tbl[12] = '{0, 0, 0, 0,     0, 0,     0, 0, 5, 5, 1,   'hB,   'hB,   0,  'hB,   'hB,   0};
        tbl[13] = '{0, 3, 7, 'h11,  7, 'h22,  0, 0, 7, 7, 1,   'h22,  'h22,  0,  0,     0,     0};
        tbl[14] = '{0, 0, 0, 0,     0, 0,     0, 0, 7, 7, 1,   'h22,  'h22,  0,  'h22,  'h22,  0};
        tbl[15] = '{0, 0, 0, 0,     0, 0,     1, 4, 4, 4, 1,   0,     0,     0,  0,     0,     0};
        tbl[16] = '{0, 0, 0, 0,     0, 0,     0, 0, 4, 5, 1,   0,     'hB,   1,  0,     'hB,   1};
        tbl[17] = '{0, 2, 0, 0,     4, 'h44,  0, 0, 4, 4, 1,   'h44,  'h44,  0,  0,     0,     3};
        tbl[18] = '{0, 0, 0, 0,     0, 0,     0, 0, 4, 4, 1,   'h44,  'h44,  0,  'h44,  'h44,  0};
        tbl[19] = '{0, 1, 4, 'h45,  0, 0,     1, 4, 4, 4, 1,   'h45,  'h45,  0,  'h44,  'h44,  0};
        tbl[20] = '{0, 0, 0, 0,     0, 0,     0, 0, 4, 4, 1,   'h45,  'h45,  3,  'h45,  'h45,  3};
        tbl[21] = '{0, 0, 0, 0,     0, 0,     1, 4, 4, 4, 1,   'h45,  'h45,  3,  'h45,  'h45,  3};
        tbl[22] = '{0, 0, 0, 0,     0, 0,     1, 0, 0, 4, 1,   0,     'h45,  2,  0,     'h45,  2};
        tbl[23] = '{0, 0, 0, 0,     0, 0,     0, 0, 0, 4, 1,   0,     'h45,  2,  0,     'h45,  2};
        tbl[24] = '{1, 0, 0, 0,     0, 0,     1, 5, 4, 5, 1,   'h45,  'hB,   1,  'h45,  'hB,   1};
        tbl[25] = '{0, 0, 0, 0,     0, 0,     0, 0, 4, 5, 1,   0,     0,     0,  0,     0,     0};

        foreach (tbl[r]) begin
            rst         = tbl[r].rst[0];
            wr_en       = tbl[r].we[NW-1:0];
            wr_addr     = {tbl[r].wa1[AW-1:0], tbl[r].wa0[AW-1:0]};
            wr_data     = {tbl[r].wd1, tbl[r].wd0};
            sb_set_en   = tbl[r].sbe[0];
            sb_set_addr = tbl[r].sba[AW-1:0];
            rd_addr     = {tbl[r].ra1[AW-1:0], tbl[r].ra0[AW-1:0]};
            @(negedge clk);
            if (tbl[r].chk != 0) begin
                check($sformatf("vec%0d a_rd0", r), rd_data_a[0 +: DW], tbl[r].ea0);
                check($sformatf("vec%0d a_rd1", r), rd_data_a[DW +: DW], tbl[r].ea1);
                check($sformatf("vec%0d a_busy", r), {30'b0, rd_busy_a}, tbl[r].eab);
                check($sformatf("vec%0d b_rd0", r), rd_data_b[0 +: DW], tbl[r].eb0);
                check($sformatf("vec%0d b_rd1", r), rd_data_b[DW +: DW], tbl[r].eb1);
                check($sformatf("vec%0d b_busy", r), {30'b0, rd_busy_b}, tbl[r].ebb);
            end
            finish_cycle();
        end

        // Random traffic on a narrowed address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            int unsigned lim;
            lim         = ($urandom_range(0, 3) == 0) ? D - 1 : 7;
            rst         = ($urandom_range(0, 39) == 0);
            wr_en       = NW'($urandom_range(0, 3));
            wr_addr     = {AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim))};
            wr_data     = {$urandom, $urandom};
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_addr = AW'($urandom_range(0, lim));
            rd_addr     = {AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim))};
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < NR; i++) begin
                    check($sformatf("rnd%0d cfg%0d rd%0d", n, j, i), pick_d(j, i), exp_data(j, i));
                    check($sformatf("rnd%0d cfg%0d busy%0d", n, j, i),
                          {31'b0, pick_b(j, i)}, {31'b0, exp_busy(j, i)});
                end
            end
            finish_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
